// File: rtl/alu_operand_stage_if.sv
// Issue-side and ALU-side bundle for the operand stage.
// Carries decode fields, forwarding taps and both handshakes.
interface alu_operand_stage_if #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  imm;
    logic              a_sel;
    logic              b_sel;
    logic [3:0]        alu_op_in;
    logic [REG_AW-1:0] rd_in;
    logic              rw_in;
    logic              fex_valid;
    logic              fwb_valid;
    logic [REG_AW-1:0] fex_rd;
    logic [REG_AW-1:0] fwb_rd;
    logic [WIDTH-1:0]  fex_data;
    logic [WIDTH-1:0]  fwb_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [3:0]        AluOp;
    logic [REG_AW-1:0] rd_out;
    logic              rw_out;

    modport master (
        output flush, in_valid,
        output rs1_addr, rs2_addr,
        output rs1_data, rs2_data,
        output pc, imm, a_sel, b_sel,
        output alu_op_in, rd_in, rw_in,
        output fex_valid, fwb_valid,
        output fex_rd, fwb_rd,
        output fex_data, fwb_data,
        output out_ready,
        input  in_ready, out_valid,
        input  A, B, AluOp,
        input  rd_out, rw_out
    );

    modport slave (
        input  flush, in_valid,
        input  rs1_addr, rs2_addr,
        input  rs1_data, rs2_data,
        input  pc, imm, a_sel, b_sel,
        input  alu_op_in, rd_in, rw_in,
        input  fex_valid, fwb_valid,
        input  fex_rd, fwb_rd,
        input  fex_data, fwb_data,
        input  out_ready,
        output in_ready, out_valid,
        output A, B, AluOp,
        output rd_out, rw_out
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwarding mux, source select and a
// two-entry skid buffer feeding registered A/B/AluOp.
module alu_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input logic                clk,
    input logic                rst_n,
    alu_operand_stage_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic              rw;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t res;
    logic   out_valid_q;
    logic   in_ready_q;
    logic   accept;
    logic   send;

    logic             rs1_ex;
    logic             rs1_wb;
    logic             rs2_ex;
    logic             rs2_wb;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;

    assign accept = bus.in_valid && in_ready_q;
    assign send   = out_valid_q && bus.out_ready;

    // x0 is hardwired zero, so it never takes a forwarded value
    assign rs1_ex = bus.fex_valid && (bus.fex_rd == bus.rs1_addr)
                    && (|bus.rs1_addr);
    assign rs1_wb = bus.fwb_valid && (bus.fwb_rd == bus.rs1_addr)
                    && (|bus.rs1_addr);
    assign rs2_ex = bus.fex_valid && (bus.fex_rd == bus.rs2_addr)
                    && (|bus.rs2_addr);
    assign rs2_wb = bus.fwb_valid && (bus.fwb_rd == bus.rs2_addr)
                    && (|bus.rs2_addr);

    always_comb begin
        rs1_val = bus.rs1_data;
        rs2_val = bus.rs2_data;
        if (rs1_ex) begin
            rs1_val = bus.fex_data;
        end else if (rs1_wb) begin
            rs1_val = bus.fwb_data;
        end
        if (rs2_ex) begin
            rs2_val = bus.fex_data;
        end else if (rs2_wb) begin
            rs2_val = bus.fwb_data;
        end
    end

    always_comb begin
        res    = '0;
        res.a  = bus.a_sel ? bus.pc : rs1_val;
        res.b  = bus.b_sel ? bus.imm : rs2_val;
        res.op = bus.alu_op_in;
        res.rd = bus.rd_in;
        res.rw = bus.rw_in;
    end

    // in_ready is registered alongside state; the skid entry
    // catches the accept that lands while it is still high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (bus.flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q      <= res;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        accept && !send: begin
                            skid_q     <= res;
                            in_ready_q <= 1'b0;
                            state      <= TWO;
                        end
                        send && !accept: begin
                            out_valid_q <= 1'b0;
                            state       <= EMPTY;
                        end
                        accept && send: begin
                            main_q <= res;
                        end
                        default: ;
                    endcase
                end
                TWO: begin
                    if (send) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.A         = main_q.a;
    assign bus.B         = main_q.b;
    assign bus.AluOp     = main_q.op;
    assign bus.rd_out    = main_q.rd;
    assign bus.rw_out    = main_q.rw;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed cases plus random
// traffic against a capacity-2 FIFO reference model.
module tb_alu_operand_stage;

    localparam int W  = 32;
    localparam int AW = 5;

    logic clk;
    logic rst_n;

    alu_operand_stage_if #(.WIDTH(W), .REG_AW(AW)) bus ();

    alu_operand_stage #(.WIDTH(W), .REG_AW(AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic          rw;
    } ent_t;

    ent_t exp_q[$];
    bit   m_ready;
    int   n_cmp;
    int   n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    function automatic logic [W-1:0] rfwd(input logic [AW-1:0] a,
                                          input logic [W-1:0] rf);
        if (a == '0) return rf;
        if (bus.fex_valid && bus.fex_rd == a) return bus.fex_data;
        if (bus.fwb_valid && bus.fwb_rd == a) return bus.fwb_data;
        return rf;
    endfunction

    function automatic ent_t ref_entry();
        ent_t e;
        e.a  = bus.a_sel ? bus.pc : rfwd(bus.rs1_addr, bus.rs1_data);
        e.b  = bus.b_sel ? bus.imm : rfwd(bus.rs2_addr, bus.rs2_data);
        e.op = bus.alu_op_in;
        e.rd = bus.rd_in;
        e.rw = bus.rw_in;
        return e;
    endfunction

    task automatic clear_in();
        bus.flush     = 0;
        bus.in_valid  = 0;
        bus.rs1_addr  = '0;
        bus.rs2_addr  = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.pc        = '0;
        bus.imm       = '0;
        bus.a_sel     = 0;
        bus.b_sel     = 0;
        bus.alu_op_in = '0;
        bus.rd_in     = '0;
        bus.rw_in     = 0;
        bus.fex_valid = 0;
        bus.fwb_valid = 0;
        bus.fex_rd    = '0;
        bus.fwb_rd    = '0;
        bus.fex_data  = '0;
        bus.fwb_data  = '0;
        bus.out_ready = 0;
    endtask

    task automatic compare_out(input string tag);
        chk({tag, "/in_ready"}, 64'(bus.in_ready), 64'(m_ready));
        chk({tag, "/out_valid"}, 64'(bus.out_valid),
            64'(exp_q.size() > 0));
        if (exp_q.size() > 0 && bus.out_valid) begin
            chk({tag, "/A"}, 64'(bus.A), 64'(exp_q[0].a));
            chk({tag, "/B"}, 64'(bus.B), 64'(exp_q[0].b));
            chk({tag, "/AluOp"}, 64'(bus.AluOp), 64'(exp_q[0].op));
            chk({tag, "/rd"}, 64'(bus.rd_out), 64'(exp_q[0].rd));
            chk({tag, "/rw"}, 64'(bus.rw_out), 64'(exp_q[0].rw));
        end
    endtask

    // Called just after a rising edge; advances one cycle.
    task automatic step(input string tag);
        bit   acc;
        bit   snd;
        ent_t e;
        acc = bus.in_valid && m_ready;
        snd = (exp_q.size() > 0) && bus.out_ready;
        e   = ref_entry();
        @(posedge clk);
        #1;
        if (bus.flush) begin
            exp_q.delete();
            m_ready = 1;
        end else begin
            if (snd) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
            m_ready = (exp_q.size() < 2);
        end
        compare_out(tag);
    endtask

    task automatic rand_in();
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        bus.flush     = ($urandom_range(0, 31) == 0);
        bus.rs1_addr  = AW'($urandom_range(0, 3));
        bus.rs2_addr  = AW'($urandom_range(0, 3));
        bus.rs1_data  = $urandom;
        bus.rs2_data  = $urandom;
        bus.pc        = $urandom;
        bus.imm       = $urandom;
        bus.a_sel     = 1'($urandom);
        bus.b_sel     = 1'($urandom);
        bus.alu_op_in = 4'($urandom);
        bus.rd_in     = AW'($urandom);
        bus.rw_in     = 1'($urandom);
        bus.fex_valid = 1'($urandom);
        bus.fwb_valid = 1'($urandom);
        bus.fex_rd    = AW'($urandom_range(0, 3));
        bus.fwb_rd    = AW'($urandom_range(0, 3));
        bus.fex_data  = $urandom;
        bus.fwb_data  = $urandom;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        m_ready = 1;
        rst_n   = 0;
        clear_in();
        #12;
        chk("rst/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst/in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst/A", 64'(bus.A), 64'd0);
        chk("rst/B", 64'(bus.B), 64'd0);
        chk("rst/AluOp", 64'(bus.AluOp), 64'd0);
        chk("rst/rd", 64'(bus.rd_out), 64'd0);
        chk("rst/rw", 64'(bus.rw_out), 64'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        bus.out_ready = 1;
        bus.in_valid  = 1;
        bus.rs1_addr  = 5'd1;
        bus.rs2_addr  = 5'd2;
        bus.rs1_data  = 32'd8;
        bus.rs2_data  = 32'd4;
        bus.alu_op_in = 4'b1000;
        step("basic");
        chk("basic/A8", 64'(bus.A), 64'd8);
        chk("basic/B4", 64'(bus.B), 64'd4);
        chk("basic/op", 64'(bus.AluOp), 64'b1000);

        bus.rs1_addr  = 5'd5;
        bus.rs1_data  = 32'd7;
        bus.fex_valid = 1;
        bus.fex_rd    = 5'd5;
        bus.fex_data  = 32'd100;
        bus.fwb_valid = 1;
        bus.fwb_rd    = 5'd5;
        bus.fwb_data  = 32'd200;
        step("fwd_ex");
        chk("fwd_ex/A100", 64'(bus.A), 64'd100);
        bus.fex_valid = 0;
        step("fwd_wb");
        chk("fwd_wb/A200", 64'(bus.A), 64'd200);
        bus.rs1_addr  = 5'd0;
        bus.fex_valid = 1;
        bus.fex_rd    = 5'd0;
        bus.fwb_rd    = 5'd0;
        step("fwd_x0");
        chk("fwd_x0/A7", 64'(bus.A), 64'd7);

        bus.a_sel = 1;
        bus.b_sel = 1;
        bus.pc    = 32'h1000;
        bus.imm   = 32'hFFFF_FFFC;
        step("srcsel");
        chk("srcsel/A", 64'(bus.A), 64'h1000);
        chk("srcsel/B", 64'(bus.B), 64'hFFFF_FFFC);

        clear_in();
        bus.out_ready = 1;
        step("drain");

        // three back-to-back offers against a stalled ALU
        bus.out_ready = 0;
        bus.in_valid  = 1;
        for (int i = 1; i <= 3; i++) begin
            bus.rd_in    = AW'(i);
            bus.rs1_data = 32'(i * 11);
            step("bp_fill");
            if (i == 2) chk("bp/ready_low", 64'(bus.in_ready), 64'd0);
        end
        chk("bp/hold_rd", 64'(bus.rd_out), 64'd1);
        bus.in_valid  = 0;
        bus.out_ready = 1;
        step("bp_drain1");
        chk("bp/second_rd", 64'(bus.rd_out), 64'd2);
        step("bp_drain2");
        chk("bp/empty", 64'(bus.out_valid), 64'd0);

        bus.out_ready = 0;
        bus.in_valid  = 1;
        bus.rd_in     = 5'd9;
        step("fl_fill1");
        bus.rd_in = 5'd10;
        step("fl_fill2");
        bus.flush = 1;
        bus.rd_in = 5'd11;
        step("flush");
        chk("flush/out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush/in_ready", 64'(bus.in_ready), 64'd1);
        bus.flush     = 0;
        bus.in_valid  = 0;
        bus.out_ready = 1;
        step("post_flush");
        chk("flush/no_leak", 64'(bus.out_valid), 64'd0);

        bus.out_ready = 0;
        bus.in_valid  = 1;
        bus.a_sel     = 1;
        bus.pc        = 32'hDEAD_0001;
        step("rs_fill1");
        step("rs_fill2");
        bus.in_valid = 0;
        chk("rs/stall_valid", 64'(bus.out_valid), 64'd1);
        #3;
        rst_n = 0;
        #1;
        exp_q.delete();
        m_ready = 1;
        chk("rs/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rs/A", 64'(bus.A), 64'd0);
        chk("rs/B", 64'(bus.B), 64'd0);
        chk("rs/in_ready", 64'(bus.in_ready), 64'd1);
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;
        compare_out("rs_after");

        for (int i = 0; i < 2000; i++) begin
            rand_in();
            step("rand");
        end

        clear_in();
        bus.out_ready = 1;
        step("final1");
        step("final2");
        chk("final/empty", 64'(bus.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
